muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Sequencer for the M-extension resource in EX.
- Accepts one MUL/DIV/REM request from EX and issues multiplies to the external fixed-latency pipelined multiplier.
- Runs an internal iterative restoring divider for DIV/DIVU/REM/REMU.
- Holds EX stalled until a one-cycle done pulse, and supports pipeline flush at any point.

Parameters:
- XLEN, 32, operand/result width.
- MUL_STAGES, 3, multiplier latency in cycles from mul_start_o to valid mul_result_i (must be >=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  EX holds an M-op; level, held with stable operands until done_o.
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in1_i  in  XLEN  forwarded rs1.
- in2_i  in  XLEN  forwarded rs2.
- flush_i  in  1  kill in-flight op.
- mul_start_o  out  1  one-cycle issue pulse to multiplier.
- mul_op_o  out  2  op_i[1:0] of the latched op.
- mul_in1_o  out  XLEN  latched operand 1.
- mul_in2_o  out  XLEN  latched operand 2.
- mul_result_i  in  XLEN  multiplier result, valid MUL_STAGES cycles after mul_start_o.
- busy_o  out  1  state != IDLE.
- stall_o  out  1  req_valid_i & ~done_o (drives ex_valid low).
- done_o  out  1  one-cycle result-valid pulse.
- result_o  out  XLEN  result; holds its value until the next done_o.

Behaviour:
- Reset: state IDLE; every output, latch and counter is 0.
- States: IDLE, MUL_ISSUE, MUL_WAIT, DIV_INIT, DIV_RUN, DIV_FIX, DONE.
- Accept: in IDLE with req_valid_i=1 and flush_i=0, latch op_i, in1_i and in2_i at the edge. Call that accept cycle N.
- Acceptance happens only in IDLE. DONE always returns to IDLE, so the held request is never re-accepted because EX advances on done_o.
- MUL path:
  - N+1 MUL_ISSUE: mul_start_o=1; counter loaded with MUL_STAGES.
  - MUL_WAIT: decrement to 0, then capture mul_result_i into result_o and go to DONE.
  - done_o is high in cycle N+MUL_STAGES+2.
- DIV path, DIV_INIT (N+1):
  - Divisor==0 → quotient all-ones (0xFFFFFFFF), remainder = dividend; go straight to DONE.
  - Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF → quotient 0x80000000, remainder 0; go to DONE.
  - Otherwise take absolute values for signed ops, record quotient sign (s1^s2) and remainder sign (s1), clear the remainder register, set count=XLEN and go to DIV_RUN.
- DIV_RUN:
  - One restoring step per cycle: shift {rem,quo} left by 1, trial subtract the divisor, set the quotient bit when there is no borrow.
  - Exit after XLEN steps.
- DIV_FIX: negate quotient/remainder per the recorded signs and select quotient (ops 4,5) or remainder (ops 6,7) into result_o.
- DIV latency: done_o at N+XLEN+3 (normal); N+2 (special cases).
- DONE: done_o=1 for one cycle, then IDLE.
- Flush:
  - flush_i=1 in any state → next state IDLE. done_o is suppressed (done_o = state==DONE & ~flush_i) and result_o is not updated.
  - A multiplier result still in flight is ignored because the counter is cleared.
  - Flush in IDLE with req_valid_i=1: no accept.
- Width: MULH* uses the upper XLEN bits of the product, selected by the external multiplier from mul_op_o; this block does not reinterpret them.
- Reset asserted mid-operation: immediate return to reset values, with no done_o.

Decomposition:
- muldiv_pkg:
  - funct3 op enum (MUL..REMU)
  - state enum
  - OPCODE_R/funct7 M-ext constant 7'b0000001
  - helper is_div(op) = op[2]
- Sub-module div_iter_step: combinational single restoring step (rem_in, quo_in, divisor → rem_out, quo_out). It is instantiated once; the FSM, counter and sign fix stay in muldiv_seq.

Test Plan:
- MUL 7*6, MUL_STAGES=3, accept at N → mul_start_o at N+1; done_o at N+5, result_o=42; stall_o low after done_o.
- DIV -20/3 → done_o at N+35, result_o=0xFFFFFFFA (-6). REM -20/3 → 0xFFFFFFFE (-2). DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF.
- DIVU 5/0 → done_o at N+2, result 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000, done at N+2. REM of the same pair → 0.
- flush_i pulsed at N+10 of a DIV → IDLE next cycle, no done_o, result_o keeps the previous value. A new MUL 3*3 then completes with 9.
- Back-to-back requests: MUL 2*2 done, then req_valid_i stays high with new operands DIVU 9/2 → exactly one accept per done_o; results 4 and 4 respectively.
- rst_ni asserted during DIV_RUN → all outputs 0 asynchronously; after release, IDLE accepts a new request.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the M-extension sequencer.
// Provides the funct3 opcode and FSM state encodings plus small decode helpers.
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MUL_ISSUE = 3'd1,
        S_MUL_WAIT  = 3'd2,
        S_DIV_INIT  = 3'd3,
        S_DIV_RUN   = 3'd4,
        S_DIV_FIX   = 3'd5,
        S_DONE      = 3'd6
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_seq_div_iter_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// The trial value is one bit wider so a large remainder never overflows before the compare.
module div_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;
    logic          no_borrow;

    assign trial     = {rem_i, quo_i[XLEN-1]};
    assign diff      = trial - {1'b0, divisor_i};
    assign no_borrow = ~diff[XLEN];
    assign rem_o     = no_borrow ? diff[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_o     = {quo_i[XLEN-2:0], no_borrow};

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer for MUL/DIV/REM in EX: issues multiplies to an external pipelined
// multiplier and runs an iterative restoring divider, pulsing done_o once per op.
//
// state       | meaning
// S_IDLE      | waiting for a request; accepts when req_valid_i & ~flush_i
// S_MUL_ISSUE | mul_start_o pulse, latency counter loaded
// S_MUL_WAIT  | counting down multiplier latency, capture on terminal count
// S_DIV_INIT  | special cases resolved, otherwise operands made unsigned
// S_DIV_RUN   | one restoring step per cycle for XLEN cycles
// S_DIV_FIX   | sign correction and quotient/remainder select
// S_DONE      | done_o pulse, back to S_IDLE
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] in1_i,
    input  logic [XLEN-1:0] in2_i,
    input  logic            flush_i,
    output logic            mul_start_o,
    output logic [1:0]      mul_op_o,
    output logic [XLEN-1:0] mul_in1_o,
    output logic [XLEN-1:0] mul_in2_o,
    input  logic [XLEN-1:0] mul_result_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d, rem_q, rem_d, quo_q, quo_d;
    logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] step_rem, step_quo, q_fix, r_fix;
    logic            signed_op, s1, s2, overflow;

    div_iter_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign signed_op = (op_q == OP_DIV) || (op_q == OP_REM);
    assign s1        = signed_op & a_q[XLEN-1];
    assign s2        = signed_op & b_q[XLEN-1];
    assign overflow  = signed_op && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == {XLEN{1'b1}});
    assign q_fix     = neg_q_q ? -quo_q : quo_q;
    assign r_fix     = neg_r_q ? -rem_q : rem_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    op_d    = op_i;
                    a_d     = in1_i;
                    b_d     = in2_i;
                    state_d = is_div(op_i) ? S_DIV_INIT : S_MUL_ISSUE;
                end
            end
            S_MUL_ISSUE: begin
                cnt_d   = CNT_W'(MUL_STAGES);
                state_d = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    result_d = mul_result_i;
                    state_d  = S_DONE;
                end
            end
            S_DIV_INIT: begin
                if (b_q == '0) begin
                    result_d = op_q[1] ? a_q : {XLEN{1'b1}};
                    state_d  = S_DONE;
                end else if (overflow) begin
                    result_d = op_q[1] ? '0 : a_q;
                    state_d  = S_DONE;
                end else begin
                    neg_q_d = s1 ^ s2;
                    neg_r_d = s1;
                    quo_d   = s1 ? -a_q : a_q;
                    dvsr_d  = s2 ? -b_q : b_q;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(XLEN);
                    state_d = S_DIV_RUN;
                end
            end
            S_DIV_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) state_d = S_DIV_FIX;
            end
            S_DIV_FIX: begin
                result_d = op_q[1] ? r_fix : q_fix;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Clearing the counter drops any multiplier result still in flight.
        if (flush_i) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign mul_start_o = (state_q == S_MUL_ISSUE) & ~flush_i;
    assign mul_op_o    = op_q[1:0];
    assign mul_in1_o   = a_q;
    assign mul_in2_o   = b_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE) & ~flush_i;
    assign stall_o     = req_valid_i & ~done_o;
    assign result_o    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized ops against
// an arithmetic reference model; also models the external pipelined multiplier.
module tb_muldiv_seq;

    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic [2:0]      op;
    logic [XLEN-1:0] in1, in2;
    logic            flush;
    logic            mul_start;
    logic [1:0]      mul_op;
    logic [XLEN-1:0] mul_in1, mul_in2, mul_result;
    logic            busy, stall, done;
    logic [XLEN-1:0] result;

    int              n_chk  = 0;
    int              n_pass = 0;
    logic [XLEN-1:0] last_res = '0;

    muldiv_seq #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .op_i         (op),
        .in1_i        (in1),
        .in2_i        (in2),
        .flush_i      (flush),
        .mul_start_o  (mul_start),
        .mul_op_o     (mul_op),
        .mul_in1_o    (mul_in1),
        .mul_in2_o    (mul_in2),
        .mul_result_i (mul_result),
        .busy_o       (busy),
        .stall_o      (stall),
        .done_o       (done),
        .result_o     (result)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension semantics from plain 64-bit arithmetic.
    function automatic logic [XLEN-1:0] model(input logic [2:0] o, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // External multiplier: result valid MUL_STAGES cycles after the start pulse, garbage otherwise.
    logic [XLEN-1:0] mpipe [MUL_STAGES];
    always @(posedge clk) begin
        mpipe[0] <= mul_start ? model({1'b0, mul_op}, mul_in1, mul_in2) : $urandom;
        for (int i = 1; i < MUL_STAGES; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_result = mpipe[MUL_STAGES-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Entered at the negedge of a cycle where the DUT should be idle; returns at the
    // negedge of the idle cycle following done, with req_valid still high.
    task automatic run_op(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] exp;
        logic            special;
        int              lat, got;
        check("idle_before_accept", busy, 0);
        req_valid = 1'b1;
        op  = o;
        in1 = a;
        in2 = b;
        exp = model(o, a, b);
        special = (b == 0) || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        lat = !o[2] ? MUL_STAGES + 2 : (special ? 2 : XLEN + 3);
        got = -1;
        for (int i = 1; i <= XLEN + 10 && got < 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("mul_start_at_n1", mul_start, !o[2]);
                check("stall_while_busy", stall, 1);
            end
            if (done) got = i;
        end
        check("done_latency", got, lat);
        if (got > 0) begin
            check("result", result, exp);
            check("stall_at_done", stall, 0);
            last_res = exp;
            @(negedge clk);
            check("single_done_then_idle", {done, busy}, 0);
        end else begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
    endtask

    task automatic flush_at(input logic [2:0] o, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input int k);
        int ndone;
        req_valid = 1'b1;
        op  = o;
        in1 = a;
        in2 = b;
        repeat (k) @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("idle_after_flush", busy, 0);
        ndone = 0;
        repeat (XLEN + 8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_done_after_flush", ndone, 0);
        check("result_kept_after_flush", result, last_res);
    endtask

    initial begin
        logic [2:0]      ro;
        logic [XLEN-1:0] ra, rb;
        rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; op = '0; in1 = '0; in2 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy_done", {busy, done, stall, mul_start}, 0);
        check("reset_result", result, 0);
        check("reset_mul_if", {mul_op, mul_in1, mul_in2}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'd7, 32'd6);
        req_valid = 1'b0;
        @(negedge clk);
        check("stall_low_after_release", stall, 0);
        run_op(3'd4, -32'sd20, 32'd3);
        run_op(3'd6, -32'sd20, 32'd3);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd6, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        req_valid = 1'b0;
        @(negedge clk);

        flush_at(3'd4, -32'sd100, 32'd7, 10);
        flush_at(3'd0, 32'h1234_5678, 32'h9abc_def0, 3);
        req_valid = 1'b1; flush = 1'b1; op = 3'd0; in1 = 32'd3; in2 = 32'd3;
        @(negedge clk);
        check("no_accept_under_flush", busy, 0);
        flush = 1'b0;
        run_op(3'd0, 32'd3, 32'd3);
        req_valid = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'd2, 32'd2);
        run_op(3'd5, 32'd9, 32'd2);
        req_valid = 1'b0;
        @(negedge clk);

        req_valid = 1'b1; op = 3'd5; in1 = 32'd1000; in2 = 32'd3;
        repeat (8) @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", {busy, done, stall, mul_start}, 0);
        check("async_reset_result", result, 0);
        check("async_reset_mul_if", {mul_op, mul_in1, mul_in2}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        @(negedge clk);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd5);
        req_valid = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = ra >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(ro, ra, rb);
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
